// File: rtl/gonso_wb_arbiter.sv
// gonso_wb_arbiter: two-master round-robin Wishbone arbiter with slave-timeout watchdog
module gonso_wb_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TO_CYCLES = 255,
  parameter int TO_W = 8,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  input  logic          err_clr_i,
  output logic          err_o,
  output logic [1:0]    grant_o
);
  typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic req0, req1, in_bus, own_cyc, own_stb, own_we, abort, done, tmo, ack;
  logic [3:0] own_sel;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat, rdat;
  // owner mux, transaction end conditions and next-state logic
  always_comb begin
    req0 = m0_cyc_i & m0_stb_i;
    req1 = m1_cyc_i & m1_stb_i;
    in_bus = state_q == BUS;
    own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
    own_stb = owner_q ? m1_stb_i : m0_stb_i;
    own_we = owner_q ? m1_we_i : m0_we_i;
    own_sel = owner_q ? m1_sel_i : m0_sel_i;
    own_adr = owner_q ? m1_adr_i : m0_adr_i;
    own_dat = owner_q ? m1_dat_i : m0_dat_i;
    abort = in_bus & ~own_cyc;
    done = in_bus & own_cyc & s_ack_i;
    tmo = in_bus & own_cyc & ~s_ack_i & (cnt_q == TO_W'(TO_CYCLES - 1));
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    cnt_d = cnt_q;
    err_d = tmo | (err_q & ~err_clr_i);
    if (state_q == IDLE && (req0 | req1)) begin
      state_d = BUS;
      owner_d = (req0 & req1) ? ~last_q : req1;
      last_d = owner_d;
      cnt_d = '0;
    end else if (in_bus) begin
      state_d = (abort | done | tmo) ? RELEASE : BUS;
      cnt_d = cnt_q + TO_W'(1);
    end else if (state_q == RELEASE) begin
      state_d = IDLE;
    end
  end
  // slave-side drive and owner return path, all zero outside BUS
  always_comb begin
    ack = done | tmo;
    rdat = tmo ? ERR_DATA : s_dat_i;
    s_cyc_o = in_bus & own_cyc & ~tmo;
    s_stb_o = in_bus & own_cyc & own_stb & ~tmo;
    s_we_o = in_bus & own_we;
    s_sel_o = in_bus ? own_sel : '0;
    s_adr_o = in_bus ? own_adr : '0;
    s_dat_o = in_bus ? own_dat : '0;
    m0_ack_o = ack & ~owner_q;
    m1_ack_o = ack & owner_q;
    m0_dat_o = (in_bus & ~owner_q) ? rdat : '0;
    m1_dat_o = (in_bus & owner_q) ? rdat : '0;
    grant_o = in_bus ? {owner_q, ~owner_q} : 2'b00;
    err_o = err_q;
  end
  // state registers; last resets to 1 so m0 wins the first tie
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_gonso_wb_arbiter.sv
// tb_gonso_wb_arbiter: directed vector table plus multi-cycle sequences for the arbiter
module tb_gonso_wb_arbiter;
  localparam logic [31:0] A0 = 32'h3000_0004;
  localparam logic [31:0] A1 = 32'h3000_0100;
  localparam logic [31:0] W0 = 32'h0000_00AA;
  localparam logic [31:0] W1 = 32'h0000_0055;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic s_ack = 0, err_clr = 0;
  logic [31:0] s_dat = '0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0] s_sel_o;
  logic m0_ack_o, m1_ack_o, s_cyc_o, s_stb_o, s_we_o, err_o;
  logic [1:0] grant_o;
  int n_cmp = 0, n_err = 0;
  gonso_wb_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(4'hF),
    .m0_adr_i(A0), .m0_dat_i(W0), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(4'h3),
    .m1_adr_i(A1), .m1_dat_i(W1), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .err_clr_i(err_clr), .err_o(err_o), .grant_o(grant_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic m0r, m0w, m1r, m1w, sa, clr;
    logic [31:0] sd;
    logic [1:0] g;
    logic sc, ss, sw;
    logic [31:0] sadr;
    logic a0, a1;
    logic [31:0] d0, d1;
    logic e;
  } vec_t;
  vec_t tbl[16];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic m0r, m0w, m1r, m1w, sa, input logic [31:0] sd, input logic clr);
    @(posedge clk);
    #1;
    m0_cyc = m0r; m0_stb = m0r; m0_we = m0w;
    m1_cyc = m1r; m1_stb = m1r; m1_we = m1w;
    s_ack = sa; s_dat = sd; err_clr = clr;
    #3;
  endtask
  task automatic run_timeout(input logic clr_last);
    int bad;
    bad = 0;
    drive(0, 0, 1, 1, 0, '0, 0);
    for (int k = 1; k <= 255; k++) begin
      drive(0, 0, 1, 1, 0, '0, clr_last & (k == 255));
      if (k == 1) begin
        chk("to_s_dat", s_dat_o, W1);
        chk("to_s_we", {31'b0, s_we_o}, 1);
        chk("to_s_sel", {28'b0, s_sel_o}, 4'h3);
      end
      if (k < 255 && (m1_ack_o || m0_ack_o || !s_cyc_o || !s_stb_o || grant_o != 2'b10)) bad++;
      if (k == 255) begin
        chk("to_ack", {31'b0, m1_ack_o}, 1);
        chk("to_dat", m1_dat_o, 32'hDEAD_BEEF);
        chk("to_m0_ack", {31'b0, m0_ack_o}, 0);
        chk("to_s_cyc", {31'b0, s_cyc_o}, 0);
        chk("to_s_stb", {31'b0, s_stb_o}, 0);
        chk("to_grant", {30'b0, grant_o}, 2'b10);
      end
    end
    chk("to_wait_cycles", bad, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int acks0, acks1;
    logic [1:0] eg;
    tbl[0]  = '{1,0,0,0,0,0,32'h0,          2'b00,0,0,0,32'h0,0,0,32'h0,32'h0,0};
    tbl[1]  = '{1,0,0,0,0,0,32'h0,          2'b01,1,1,0,A0,   0,0,32'h0,32'h0,0};
    tbl[2]  = '{1,0,0,0,0,0,32'h0,          2'b01,1,1,0,A0,   0,0,32'h0,32'h0,0};
    tbl[3]  = '{1,0,0,0,1,0,32'h1234_5678,  2'b01,1,1,0,A0,   1,0,32'h1234_5678,32'h0,0};
    tbl[4]  = '{0,0,0,0,0,0,32'h0,          2'b00,0,0,0,32'h0,0,0,32'h0,32'h0,0};
    tbl[5]  = '{0,0,0,0,0,0,32'h0,          2'b00,0,0,0,32'h0,0,0,32'h0,32'h0,0};
    tbl[6]  = '{1,1,0,0,0,0,32'h0,          2'b00,0,0,0,32'h0,0,0,32'h0,32'h0,0};
    tbl[7]  = '{1,1,0,0,0,0,32'h0,          2'b01,1,1,1,A0,   0,0,32'h0,32'h0,0};
    tbl[8]  = '{1,1,0,0,0,0,32'h0,          2'b01,1,1,1,A0,   0,0,32'h0,32'h0,0};
    tbl[9]  = '{0,1,0,0,0,0,32'h0,          2'b01,0,0,1,A0,   0,0,32'h0,32'h0,0};
    tbl[10] = '{0,0,0,0,0,0,32'h0,          2'b00,0,0,0,32'h0,0,0,32'h0,32'h0,0};
    tbl[11] = '{0,0,0,0,0,0,32'h0,          2'b00,0,0,0,32'h0,0,0,32'h0,32'h0,0};
    tbl[12] = '{0,0,1,0,0,0,32'h0,          2'b00,0,0,0,32'h0,0,0,32'h0,32'h0,0};
    tbl[13] = '{0,0,1,0,0,0,32'h0,          2'b10,1,1,0,A1,   0,0,32'h0,32'h0,0};
    tbl[14] = '{0,0,1,0,1,0,32'hA5A5_0001,  2'b10,1,1,0,A1,   0,1,32'h0,32'hA5A5_0001,0};
    tbl[15] = '{0,0,0,0,0,0,32'h0,          2'b00,0,0,0,32'h0,0,0,32'h0,32'h0,0};
    #12;
    chk("rst_grant", {30'b0, grant_o}, 0);
    chk("rst_s_cyc", {31'b0, s_cyc_o}, 0);
    chk("rst_s_stb", {31'b0, s_stb_o}, 0);
    chk("rst_acks", {30'b0, m0_ack_o, m1_ack_o}, 0);
    chk("rst_dats", m0_dat_o | m1_dat_o, 0);
    chk("rst_err", {31'b0, err_o}, 0);
    rst = 1'b0;
    acks0 = 0;
    acks1 = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1, 0, 1, 0, 1, 32'h0000_1000 + i, 0);
      eg = (i % 3 != 1) ? 2'b00 : ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr%0d_grant", i), {30'b0, grant_o}, eg);
      chk($sformatf("rr%0d_acks", i), {30'b0, m1_ack_o, m0_ack_o}, eg);
      acks0 += m0_ack_o;
      acks1 += m1_ack_o;
    end
    chk("rr_m0_acks", acks0, 4);
    chk("rr_m1_acks", acks1, 4);
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].m0r, tbl[i].m0w, tbl[i].m1r, tbl[i].m1w, tbl[i].sa, tbl[i].sd, tbl[i].clr);
      chk($sformatf("v%0d_grant", i), {30'b0, grant_o}, {30'b0, tbl[i].g});
      chk($sformatf("v%0d_s_cyc_stb_we", i), {29'b0, s_cyc_o, s_stb_o, s_we_o}, {29'b0, tbl[i].sc, tbl[i].ss, tbl[i].sw});
      chk($sformatf("v%0d_s_adr", i), s_adr_o, tbl[i].sadr);
      chk($sformatf("v%0d_acks", i), {30'b0, m0_ack_o, m1_ack_o}, {30'b0, tbl[i].a0, tbl[i].a1});
      chk($sformatf("v%0d_m0_dat", i), m0_dat_o, tbl[i].d0);
      chk($sformatf("v%0d_m1_dat", i), m1_dat_o, tbl[i].d1);
      chk($sformatf("v%0d_err", i), {31'b0, err_o}, {31'b0, tbl[i].e});
    end
    run_timeout(0);
    drive(0, 0, 0, 0, 0, '0, 0);
    chk("to_rel_err", {31'b0, err_o}, 1);
    chk("to_rel_grant", {30'b0, grant_o}, 0);
    repeat (3) drive(0, 0, 0, 0, 0, '0, 0);
    chk("err_sticky", {31'b0, err_o}, 1);
    drive(0, 0, 0, 0, 0, '0, 1);
    chk("err_clr_pending", {31'b0, err_o}, 1);
    drive(0, 0, 0, 0, 0, '0, 0);
    chk("err_cleared", {31'b0, err_o}, 0);
    drive(1, 0, 0, 0, 0, '0, 0);
    drive(1, 0, 0, 0, 1, 32'hCAFE_0000, 0);
    chk("post_to_ack", {31'b0, m0_ack_o}, 1);
    chk("post_to_dat", m0_dat_o, 32'hCAFE_0000);
    drive(0, 0, 0, 0, 0, '0, 0);
    run_timeout(1);
    drive(0, 0, 0, 0, 0, '0, 0);
    chk("set_wins_err", {31'b0, err_o}, 1);
    drive(0, 0, 0, 0, 0, '0, 0);
    drive(1, 0, 0, 0, 0, '0, 0);
    drive(1, 0, 0, 0, 0, '0, 0);
    chk("pre_rst_s_cyc", {31'b0, s_cyc_o}, 1);
    chk("pre_rst_grant", {30'b0, grant_o}, 2'b01);
    #1;
    rst = 1'b1;
    s_ack = 1'b1;
    m1_cyc = 1'b1;
    m1_stb = 1'b1;
    #1;
    chk("arst_s_cyc", {31'b0, s_cyc_o}, 0);
    chk("arst_grant", {30'b0, grant_o}, 0);
    chk("arst_acks", {30'b0, m0_ack_o, m1_ack_o}, 0);
    chk("arst_err", {31'b0, err_o}, 0);
    #1;
    rst = 1'b0;
    s_ack = 1'b0;
    drive(1, 0, 1, 0, 0, '0, 0);
    chk("arst_tie_grant", {30'b0, grant_o}, 2'b01);
    chk("arst_tie_adr", s_adr_o, A0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
